// File: rtl/user_gpio_axil_slave.sv
// AXI4-Lite register slave for the user GPIO block: output/direction/IRQ-enable/
// scratch registers, synchronised input readback and a rising-edge level interrupt.
module user_gpio_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_GPIO_WIDTH       = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [C_GPIO_WIDTH-1:0]         gpio_in,
    output logic [C_GPIO_WIDTH-1:0]         gpio_out,
    output logic [C_GPIO_WIDTH-1:0]         gpio_oe,
    output logic                            irq
);

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFFF >> (32 - C_GPIO_WIDTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Expands the four byte strobes into a 32-bit lane mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Replaces only the strobed lanes of old_v with new_v.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    wr_state_t   wr_state_q;
    rd_state_t   rd_state_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q, irq_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [2:0]  awidx_q;
    logic [31:0] wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] out_q, dir_q, irq_en_q, scratch_q, irq_status_q;
    logic [31:0] out_d, dir_d, irq_en_d, scratch_d, irq_status_d;
    logic [31:0] sync1_q, sync2_q, prev_q, gpio_in_ext;
    logic        aw_hs, w_hs, ar_hs, wr_commit, wr_err, rd_err;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data, bmask, clr, edge_set, rd_val;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;

    // Selects the address/data pair that completes a write this cycle.
    always_comb begin
        wr_commit = 1'b0;
        wr_idx    = S_AXI_AWADDR[4:2];
        wr_data   = S_AXI_WDATA;
        bmask     = strb_mask(S_AXI_WSTRB);
        case (wr_state_q)
            WR_IDLE:   wr_commit = aw_hs & w_hs;
            WR_HAVE_A: begin wr_commit = w_hs;  wr_idx = awidx_q; end
            WR_HAVE_D: begin wr_commit = aw_hs; wr_data = wdata_q; bmask = strb_mask(wstrb_q); end
            default:   wr_commit = 1'b0;
        endcase
        wr_err = (wr_idx[2:1] == 2'b11);
    end

    // Next-state of the register file, edge detection and W1C clearing.
    always_comb begin
        gpio_in_ext = '0;
        gpio_in_ext[C_GPIO_WIDTH-1:0] = gpio_in;
        out_d     = out_q;
        dir_d     = dir_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        clr       = '0;
        if (wr_commit) begin
            case (wr_idx)
                3'd0:    out_d     = merge(out_q, wr_data, bmask) & GPIO_MASK;
                3'd1:    dir_d     = merge(dir_q, wr_data, bmask) & GPIO_MASK;
                3'd2:    irq_en_d  = merge(irq_en_q, wr_data, bmask) & GPIO_MASK;
                3'd3:    scratch_d = merge(scratch_q, wr_data, bmask);
                3'd5:    clr       = wr_data & bmask;
                default: clr       = '0;
            endcase
        end
        // A new edge on a bit outranks a simultaneous clear of that bit.
        edge_set     = sync2_q & ~prev_q & irq_en_q;
        irq_status_d = ((irq_status_q & ~clr) | edge_set) & GPIO_MASK;
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_err = 1'b0;
        case (S_AXI_ARADDR[4:2])
            3'd0:    rd_val = out_q;
            3'd1:    rd_val = dir_q;
            3'd2:    rd_val = irq_en_q;
            3'd3:    rd_val = scratch_q;
            3'd4:    rd_val = sync2_q;
            3'd5:    rd_val = irq_status_q;
            default: begin rd_val = '0; rd_err = 1'b1; end
        endcase
    end

    // Write channel FSM: latches whichever of AW/W arrives first, then responds.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            if (wr_commit) begin
                wr_state_q <= WR_RESP;
                awready_q  <= 1'b0;
                wready_q   <= 1'b0;
                bvalid_q   <= 1'b1;
                bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                case (wr_state_q)
                    WR_IDLE: begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        if (aw_hs) begin
                            wr_state_q <= WR_HAVE_A;
                            awidx_q    <= S_AXI_AWADDR[4:2];
                            awready_q  <= 1'b0;
                        end else if (w_hs) begin
                            wr_state_q <= WR_HAVE_D;
                            wdata_q    <= S_AXI_WDATA;
                            wstrb_q    <= S_AXI_WSTRB;
                            wready_q   <= 1'b0;
                        end
                    end
                    WR_RESP: begin
                        if (S_AXI_BREADY) begin
                            wr_state_q <= WR_IDLE;
                            bvalid_q   <= 1'b0;
                            awready_q  <= 1'b1;
                            wready_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read channel FSM: one-cycle registered read, held until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rd_state_q <= RD_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_val;
                        rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                default: begin
                    if (S_AXI_RREADY) begin
                        rd_state_q <= RD_IDLE;
                        arready_q  <= 1'b1;
                        rvalid_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Register file, input synchroniser, edge delay flop and interrupt output.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            out_q        <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            scratch_q    <= '0;
            irq_status_q <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            irq_q        <= 1'b0;
        end else begin
            out_q        <= out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            scratch_q    <= scratch_d;
            irq_status_q <= irq_status_d;
            sync1_q      <= gpio_in_ext;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            irq_q        <= |irq_status_q;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign gpio_out      = out_q[C_GPIO_WIDTH-1:0];
    assign gpio_oe       = dir_q[C_GPIO_WIDTH-1:0];
    assign irq           = irq_q;

endmodule
